// File: rtl/r16_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : r16_pkg
//  Purpose  : Shared types and constants for the radix-16 NTT modulus
//             parameter controller.
//  Revision : 1.0 - initial release
// ============================================================================
package r16_pkg;

    // Default modulus width; Ninv2 is one bit wider.
    localparam int c_p_width_def  = 64;

    // Width of the settle-window down-counter (SETTLE_CYC up to 255).
    localparam int c_settle_cnt_w = 8;

    // Reconfiguration sequencer states. LOAD_NINV is part of the state set
    // but the ninv2 launch happens on the DRAIN exit edge, so it is only
    // reachable through corruption and recovers to IDLE.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DRAIN     = 3'd1,
        S_LOAD_NINV = 3'd2,
        S_LOAD_N    = 3'd3,
        S_SETTLE    = 3'd4
    } r16_pctl_state_t;

endpackage : r16_pkg
`default_nettype wire

// File: rtl/r16_param_settle_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : r16_param_settle_cnt
//  Purpose  : Loadable down-counter with a zero flag, used to time the
//             settle window after the modulus N is launched.
//  Revision : 1.0 - initial release
// ============================================================================
module r16_param_settle_cnt
    import r16_pkg::*;
#(
    parameter int CNT_W = c_settle_cnt_w
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] r_cnt;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= val;
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule : r16_param_settle_cnt
`default_nettype wire

// File: rtl/r16_mod_param_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : r16_mod_param_ctrl
//  Purpose  : Sequences modulus (N, Ninv2) reconfiguration for the radix-16
//             NTT butterfly pipeline: stall, drain, launch Ninv2 one cycle
//             ahead of N, settle, then release the datapath.
//  Revision : 1.0 - initial release
// ============================================================================
module r16_mod_param_ctrl
    import r16_pkg::*;
#(
    parameter int P_WIDTH    = c_p_width_def,
    parameter int SETTLE_CYC = 4
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [P_WIDTH-1:0] cfg_n,
    input  logic [P_WIDTH:0]   cfg_ninv2,
    input  logic               pipe_busy,
    output logic               hold_req,
    output logic [P_WIDTH-1:0] n_out,
    output logic [P_WIDTH:0]   ninv2_out,
    output logic               param_valid,
    output logic               update_done,
    output logic               cfg_err
);

    // The counter is loaded with SETTLE_CYC-1 so that the zero test on the
    // final SETTLE edge lands exactly SETTLE_CYC edges after N is launched.
    localparam logic [c_settle_cnt_w-1:0] c_settle_load = c_settle_cnt_w'(SETTLE_CYC - 1);

    r16_pctl_state_t    r_state, w_state_nxt;

    logic [P_WIDTH-1:0] r_sh_n,      w_sh_n_nxt;
    logic [P_WIDTH:0]   r_sh_ninv2,  w_sh_ninv2_nxt;
    logic [P_WIDTH-1:0] r_n_out,     w_n_out_nxt;
    logic [P_WIDTH:0]   r_ninv2_out, w_ninv2_out_nxt;
    logic               r_cfg_ready, w_cfg_ready_nxt;
    logic               r_hold_req,  w_hold_req_nxt;
    logic               r_param_vld, w_param_vld_nxt;
    logic               r_upd_done,  w_upd_done_nxt;
    logic               r_cfg_err,   w_cfg_err_nxt;

    logic               w_cnt_load;
    logic               w_cnt_en;
    logic               w_cnt_zero;

    assign w_cnt_load = (r_state == S_LOAD_N);
    assign w_cnt_en   = (r_state == S_SETTLE);

    r16_param_settle_cnt #(
        .CNT_W (c_settle_cnt_w)
    ) u_settle_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (w_cnt_load),
        .val  (c_settle_load),
        .en   (w_cnt_en),
        .zero (w_cnt_zero)
    );

    // State, shadow and output registers; reset aborts any sequence in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sh_n      <= '0;
            r_sh_ninv2  <= '0;
            r_n_out     <= '0;
            r_ninv2_out <= '0;
            r_cfg_ready <= 1'b1;
            r_hold_req  <= 1'b0;
            r_param_vld <= 1'b0;
            r_upd_done  <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sh_n      <= w_sh_n_nxt;
            r_sh_ninv2  <= w_sh_ninv2_nxt;
            r_n_out     <= w_n_out_nxt;
            r_ninv2_out <= w_ninv2_out_nxt;
            r_cfg_ready <= w_cfg_ready_nxt;
            r_hold_req  <= w_hold_req_nxt;
            r_param_vld <= w_param_vld_nxt;
            r_upd_done  <= w_upd_done_nxt;
            r_cfg_err   <= w_cfg_err_nxt;
        end
    end

    // Next-state and next-output decode; pulses default low, everything else holds.
    always_comb begin
        w_state_nxt     = r_state;
        w_sh_n_nxt      = r_sh_n;
        w_sh_ninv2_nxt  = r_sh_ninv2;
        w_n_out_nxt     = r_n_out;
        w_ninv2_out_nxt = r_ninv2_out;
        w_cfg_ready_nxt = r_cfg_ready;
        w_hold_req_nxt  = r_hold_req;
        w_param_vld_nxt = r_param_vld;
        w_upd_done_nxt  = 1'b0;
        w_cfg_err_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (cfg_valid && r_cfg_ready) begin
                    w_sh_n_nxt     = cfg_n;
                    w_sh_ninv2_nxt = cfg_ninv2;
                    // An odd modulus is the only legal one (and is never zero).
                    if (cfg_n[0]) begin
                        w_state_nxt     = S_DRAIN;
                        w_hold_req_nxt  = 1'b1;
                        w_cfg_ready_nxt = 1'b0;
                    end else begin
                        w_cfg_err_nxt   = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // In-flight samples still use the old modulus, so param_valid
                // only drops once the pipeline is empty and Ninv2 moves.
                if (!pipe_busy) begin
                    w_ninv2_out_nxt = r_sh_ninv2;
                    w_param_vld_nxt = 1'b0;
                    w_state_nxt     = S_LOAD_N;
                end
            end
            S_LOAD_N: begin
                w_n_out_nxt = r_sh_n;
                w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (w_cnt_zero) begin
                    w_param_vld_nxt = 1'b1;
                    w_upd_done_nxt  = 1'b1;
                    w_hold_req_nxt  = 1'b0;
                    w_cfg_ready_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end
            end
            S_LOAD_NINV: begin
                w_hold_req_nxt  = 1'b0;
                w_cfg_ready_nxt = 1'b1;
                w_state_nxt     = S_IDLE;
            end
            default: begin
                w_hold_req_nxt  = 1'b0;
                w_cfg_ready_nxt = 1'b1;
                w_state_nxt     = S_IDLE;
            end
        endcase
    end

    assign cfg_ready   = r_cfg_ready;
    assign hold_req    = r_hold_req;
    assign n_out       = r_n_out;
    assign ninv2_out   = r_ninv2_out;
    assign param_valid = r_param_vld;
    assign update_done = r_upd_done;
    assign cfg_err     = r_cfg_err;

endmodule : r16_mod_param_ctrl
`default_nettype wire

// File: tb/tb_r16_mod_param_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_r16_mod_param_ctrl
//  Purpose  : Directed self-checking bench for r16_mod_param_ctrl, covering
//             the default build and a SETTLE_CYC=1 build side by side.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_r16_mod_param_ctrl;

    localparam int c_pw = 64;

    localparam logic [63:0] c_n1  = 64'hFFFF_FFFF_0000_0001;
    localparam logic [64:0] c_ni1 = 65'h0_7FFF_FFFF_8000_0001;
    localparam logic [63:0] c_n2  = 64'h1234_5678_9ABC_DEF1;
    localparam logic [64:0] c_ni2 = 65'h1_0000_0000_0000_0003;
    localparam logic [63:0] c_n3  = 64'hFFFF_FFFF_FFFF_FFC5;
    localparam logic [64:0] c_ni3 = 65'h0_0000_0000_0000_0007;
    localparam logic [63:0] c_na  = 64'h0000_0000_0000_0101;
    localparam logic [64:0] c_nia = 65'h1_FFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] c_nb  = 64'h8000_0000_0000_0001;
    localparam logic [64:0] c_nib = 65'h0_4000_0000_0000_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_valid;
    logic [63:0]     cfg_n;
    logic [64:0]     cfg_ninv2;
    logic            pipe_busy;

    logic            cfg_ready,   cfg_ready1;
    logic            hold_req,    hold_req1;
    logic [63:0]     n_out,       n_out1;
    logic [64:0]     ninv2_out,   ninv2_out1;
    logic            param_valid, param_valid1;
    logic            update_done, update_done1;
    logic            cfg_err,     cfg_err1;

    int n_cmp = 0;
    int n_err = 0;

    // Observation vector: {hold, ready, pvalid, done, err, n, ninv2}
    logic [133:0] obs, obs1, exp_v;

    assign obs  = {hold_req,  cfg_ready,  param_valid,  update_done,  cfg_err,  n_out,  ninv2_out};
    assign obs1 = {hold_req1, cfg_ready1, param_valid1, update_done1, cfg_err1, n_out1, ninv2_out1};

    r16_mod_param_ctrl #(.P_WIDTH(c_pw), .SETTLE_CYC(4)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_n(cfg_n), .cfg_ninv2(cfg_ninv2), .pipe_busy(pipe_busy),
        .hold_req(hold_req), .n_out(n_out), .ninv2_out(ninv2_out),
        .param_valid(param_valid), .update_done(update_done), .cfg_err(cfg_err)
    );

    r16_mod_param_ctrl #(.P_WIDTH(c_pw), .SETTLE_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready1),
        .cfg_n(cfg_n), .cfg_ninv2(cfg_ninv2), .pipe_busy(pipe_busy),
        .hold_req(hold_req1), .n_out(n_out1), .ninv2_out(ninv2_out1),
        .param_valid(param_valid1), .update_done(update_done1), .cfg_err(cfg_err1)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [133:0] mk(input logic h, input logic r, input logic p,
                                        input logic d, input logic e,
                                        input logic [63:0] n, input logic [64:0] ni);
        return {h, r, p, d, e, n, ni};
    endfunction

    task automatic test_reset();
        rst = 1'b1; cfg_valid = 1'b0; cfg_n = '0; cfg_ninv2 = '0; pipe_busy = 1'b0;
        tick();
        tick();
        exp_v = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 65'h0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL reset_state got %h exp %h", obs, exp_v);
        end
        n_cmp++;
        if (obs1 !== exp_v) begin
            n_err++; $display("FAIL reset_state_s1 got %h exp %h", obs1, exp_v);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL reset_idle got %h exp %h", obs, exp_v);
        end
    endtask

    task automatic test_basic();
        cfg_valid = 1'b1; cfg_n = c_n1; cfg_ninv2 = c_ni1; pipe_busy = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            tick();
            cfg_valid = 1'b0;
            exp_v = mk(k < 6, k >= 6, k >= 6, k == 6, 1'b0,
                       (k >= 2) ? c_n1 : 64'h0, (k >= 1) ? c_ni1 : 65'h0);
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++; $display("FAIL basic k=%0d got %h exp %h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_drain();
        cfg_valid = 1'b1; cfg_n = c_n2; cfg_ninv2 = c_ni2; pipe_busy = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            tick();
            cfg_valid = 1'b0;
            exp_v = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, c_n1, c_ni1);
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++; $display("FAIL drain_hold k=%0d got %h exp %h", k, obs, exp_v);
            end
        end
        pipe_busy = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            tick();
            exp_v = mk(j < 6, j >= 6, j >= 6, j == 6, 1'b0,
                       (j >= 2) ? c_n2 : c_n1, c_ni2);
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++; $display("FAIL drain_tail j=%0d got %h exp %h", j, obs, exp_v);
            end
        end
    endtask

    task automatic test_illegal();
        cfg_valid = 1'b1; cfg_n = 64'h10; cfg_ninv2 = 65'h5;
        tick();
        cfg_valid = 1'b0;
        exp_v = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, c_n2, c_ni2);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL illegal_pulse got %h exp %h", obs, exp_v);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_v = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, c_n2, c_ni2);
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++; $display("FAIL illegal_after k=%0d got %h exp %h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_settle();
        cfg_valid = 1'b1; cfg_n = c_n3; cfg_ninv2 = c_ni3; pipe_busy = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            tick();
            cfg_valid = 1'b0;
        end
        exp_v = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, c_n3, c_ni3);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL settle_entry got %h exp %h", obs, exp_v);
        end
        rst = 1'b1;
        // pipe_busy toggles here too; it must have no effect on reset or idle.
        pipe_busy = 1'b1;
        tick();
        rst = 1'b0;
        exp_v = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 65'h0);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL settle_reset got %h exp %h", obs, exp_v);
        end
        pipe_busy = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++; $display("FAIL settle_abort k=%0d got %h exp %h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        cfg_valid = 1'b1; cfg_n = c_na; cfg_ninv2 = c_nia; pipe_busy = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            tick();
            // Second pair is offered immediately and held until accepted.
            cfg_n = c_nb; cfg_ninv2 = c_nib;
            exp_v = mk(k < 6, k >= 6, k >= 6, k == 6, 1'b0,
                       (k >= 2) ? c_na : 64'h0, (k >= 1) ? c_nia : 65'h0);
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++; $display("FAIL b2b_first k=%0d got %h exp %h", k, obs, exp_v);
            end
        end
        tick();
        cfg_valid = 1'b0;
        exp_v = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, c_na, c_nia);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL b2b_accept got %h exp %h", obs, exp_v);
        end
        for (int j = 1; j <= 7; j++) begin
            tick();
            exp_v = mk(j < 6, j >= 6, j >= 6, j == 6, 1'b0,
                       (j >= 2) ? c_nb : c_na, c_nib);
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++; $display("FAIL b2b_second j=%0d got %h exp %h", j, obs, exp_v);
            end
        end
    endtask

    task automatic test_settle_one();
        rst = 1'b1; cfg_valid = 1'b0; pipe_busy = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        cfg_valid = 1'b1; cfg_n = c_n1; cfg_ninv2 = c_ni1;
        for (int k = 0; k <= 4; k++) begin
            tick();
            cfg_valid = 1'b0;
            exp_v = mk(k < 3, k >= 3, k >= 3, k == 3, 1'b0,
                       (k >= 2) ? c_n1 : 64'h0, (k >= 1) ? c_ni1 : 65'h0);
            n_cmp++;
            if (obs1 !== exp_v) begin
                n_err++; $display("FAIL settle1 k=%0d got %h exp %h", k, obs1, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drain();
        test_illegal();
        test_reset_settle();
        test_back_to_back();
        test_settle_one();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout run did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_r16_mod_param_ctrl
`default_nettype wire
